// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sseg_pkg
// Purpose  : Shared segment glyph constants and sizing helpers for the
//            seven-segment scan controller.
// Revision : 1.0
// ============================================================================
package sseg_pkg;

   // Active-high glyphs, bit0 = segment a .. bit6 = segment g
   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_hex_decode.sv
`default_nettype none
// ============================================================================
// Module   : sseg_hex_decode
// Purpose  : Combinational 4-bit hex to 7-bit active-high segment map.
// Revision : 1.0
// ============================================================================
module sseg_hex_decode
   import sseg_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_0;
      case (i_nib)
         4'h0:    o_seg = SEG_0;
         4'h1:    o_seg = SEG_1;
         4'h2:    o_seg = SEG_2;
         4'h3:    o_seg = SEG_3;
         4'h4:    o_seg = SEG_4;
         4'h5:    o_seg = SEG_5;
         4'h6:    o_seg = SEG_6;
         4'h7:    o_seg = SEG_7;
         4'h8:    o_seg = SEG_8;
         4'h9:    o_seg = SEG_9;
         4'hA:    o_seg = SEG_A;
         4'hB:    o_seg = SEG_B;
         4'hC:    o_seg = SEG_C;
         4'hD:    o_seg = SEG_D;
         4'hE:    o_seg = SEG_E;
         default: o_seg = SEG_F;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_ctrl
// Purpose  : N-digit multiplexed seven-segment driver with PWM brightness and
//            frame-synchronous load. Define SSEG_LZB_EN for leading-zero blanking.
// Revision : 1.0
// ============================================================================
module sseg_scan_ctrl
   import sseg_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int PRESCALE   = 20000,
   parameter int DUTY_W     = 4
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic                    load,
   input  logic [DUTY_W-1:0]       duty,
   output logic                    load_pending,
   output logic                    frame_tick,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [7:0]              sseg
);

   localparam int IDX_W  = idx_width(NUM_DIGITS);
   localparam int SLOT_W = $clog2(PRESCALE);
   localparam logic [SLOT_W-1:0] c_slot_last = SLOT_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(NUM_DIGITS - 1);

   logic [SLOT_W-1:0]       r_slot;
   logic [IDX_W-1:0]        r_idx;
   logic [DUTY_W-1:0]       r_pwm;
   logic [4*NUM_DIGITS-1:0] r_val;
   logic [NUM_DIGITS-1:0]   r_dp;
   logic [NUM_DIGITS-1:0]   r_blank;
   logic                    r_pend;
   logic                    r_tick;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [7:0]              r_sseg;

   logic                    w_slot_wrap;
   logic                    w_frame_end;
   logic [3:0]              w_nib;
   logic                    w_dp_sel;
   logic                    w_blank_sel;
   logic                    w_lz_sel;
   logic [NUM_DIGITS-1:0]   w_lz;
   logic [6:0]              w_seg;
   logic [6:0]              w_seg_sel;
   logic                    w_lit;
   logic                    w_on;
   logic [NUM_DIGITS-1:0]   w_onehot;

   assign w_slot_wrap = (r_slot == c_slot_last);
   assign w_frame_end = w_slot_wrap && (r_idx == c_idx_last);

   always_comb begin
      w_nib       = 4'h0;
      w_dp_sel    = 1'b0;
      w_blank_sel = 1'b0;
      w_lz_sel    = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_nib       = r_val[4*i +: 4];
            w_dp_sel    = r_dp[i];
            w_blank_sel = r_blank[i];
            w_lz_sel    = w_lz[i];
         end
      end
   end

`ifdef SSEG_LZB_EN
   // A digit is a leading zero when it and every digit above it are zero
   always_comb begin
      logic v_zero;
      v_zero = 1'b1;
      w_lz   = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         v_zero  = v_zero & (r_val[4*i +: 4] == 4'h0);
         w_lz[i] = v_zero;
      end
   end
`else
   assign w_lz = '0;
`endif

   sseg_hex_decode u_hex (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

   // Suppressed leading zeros stay driven only if their decimal point is lit
   assign w_seg_sel = w_lz_sel ? 7'h00 : w_seg;
   assign w_lit     = (r_pwm < duty) || (&duty);
   assign w_on      = w_lit && !w_blank_sel && !(w_lz_sel && !w_dp_sel);
   assign w_onehot  = NUM_DIGITS'(1) << r_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slot  <= '0;
         r_idx   <= '0;
         r_pwm   <= '0;
         r_val   <= '0;
         r_dp    <= '0;
         r_blank <= '0;
         r_pend  <= 1'b0;
         r_tick  <= 1'b0;
         r_an    <= '1;
         r_sseg  <= SEG_OFF;
      end else begin
         r_pwm  <= r_pwm + 1'b1;
         r_tick <= w_frame_end;

         if (w_slot_wrap) begin
            r_slot <= '0;
            r_idx  <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
         end else begin
            r_slot <= r_slot + 1'b1;
         end

         // A load arriving on the frame-end cycle itself is taken at once
         if (w_frame_end && (r_pend || load)) begin
            r_val   <= value;
            r_dp    <= dp_in;
            r_blank <= blank;
            r_pend  <= 1'b0;
         end else if (load) begin
            r_pend  <= 1'b1;
         end

         r_an   <= w_on ? ~w_onehot : '1;
         r_sseg <= w_on ? ~{w_dp_sel, w_seg_sel} : SEG_OFF;
      end
   end

   assign load_pending = r_pend;
   assign frame_tick   = r_tick;
   assign an           = r_an;
   assign sseg         = r_sseg;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_ctrl
// Purpose  : Self-checking bench for sseg_scan_ctrl (4 digits, prescale 4).
// Revision : 1.0
// ============================================================================
module tb_sseg_scan_ctrl;

   localparam int N = 4;
   localparam int P = 4;
   localparam int DW = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  dp_in = 4'h0;
   logic [3:0]  blank = 4'h0;
   logic        load = 1'b0;
   logic [3:0]  duty = 4'hF;
   logic        load_pending;
   logic        frame_tick;
   logic [3:0]  an;
   logic [7:0]  sseg;

   int checks = 0;
   int errors = 0;

   int          c;
   logic        m_pend;
   logic [15:0] m_val;
   logic [3:0]  m_dp;
   logic [3:0]  m_blank;

   sseg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(P), .DUTY_W(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .value        (value),
      .dp_in        (dp_in),
      .blank        (blank),
      .load         (load),
      .duty         (duty),
      .load_pending (load_pending),
      .frame_tick   (frame_tick),
      .an           (an),
      .sseg         (sseg)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
         4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
         4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
         4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, c);
      end
   endtask

   task automatic model_reset();
      c       = 0;
      m_pend  = 1'b0;
      m_val   = 16'h0;
      m_dp    = 4'h0;
      m_blank = 4'h0;
   endtask

   // One clock: predict from cycle count and model shadow, then compare
   task automatic step();
      int         idx;
      int         pwm;
      logic       on;
      logic       fe;
      logic [3:0] oh;
      logic [3:0] e_an;
      logic [7:0] e_sseg;
      idx    = (c / P) % N;
      pwm    = c % 16;
      on     = ((pwm < int'(duty)) || (duty == 4'hF)) && !m_blank[idx];
      oh     = 4'b0001 << idx;
      e_an   = on ? ~oh : 4'hF;
      e_sseg = on ? ~{m_dp[idx], hex7(m_val[4*idx +: 4])} : 8'hFF;
      fe     = ((c % (P*N)) == (P*N - 1));
      if (fe && (m_pend || load)) begin
         m_val   = value;
         m_dp    = dp_in;
         m_blank = blank;
         m_pend  = 1'b0;
      end else if (load) begin
         m_pend  = 1'b1;
      end
      c++;
      @(posedge clk);
      #1;
      chk("an", {4'h0, an}, {4'h0, e_an});
      chk("sseg", sseg, e_sseg);
      chk("frame_tick", {7'h0, frame_tick}, {7'h0, fe});
      chk("load_pending", {7'h0, load_pending}, {7'h0, m_pend});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic align(input int phase);
      while ((c % (P*N)) != phase) step();
   endtask

   initial begin
      model_reset();
      #2 rst = 1'b1;
      #1;
      chk("reset_an", {4'h0, an}, 8'h0F);
      chk("reset_sseg", sseg, 8'hFF);
      chk("reset_tick", {7'h0, frame_tick}, 8'h00);
      chk("reset_pend", {7'h0, load_pending}, 8'h00);
      #20 rst = 1'b0;

      // Idle scan, full brightness, shadow all zero
      run(40);

      // Mid-frame load
      value = 16'h12AF;
      align(5);
      load = 1'b1;
      step();
      load = 1'b0;
      run(36);

      // Load exactly on the frame-end cycle
      value = 16'h9C3D;
      align(15);
      load = 1'b1;
      step();
      load = 1'b0;
      run(20);

      // Reduced and zero brightness
      duty = 4'd4;
      run(32);
      duty = 4'd0;
      run(32);

      // Blank mask and decimal point
      duty  = 4'hF;
      blank = 4'b0100;
      dp_in = 4'b0001;
      value = 16'h0050;
      load  = 1'b1;
      step();
      load  = 1'b0;
      run(40);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         value = 16'($urandom);
         dp_in = 4'($urandom_range(0, 15));
         blank = 4'($urandom_range(0, 15));
         load  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) duty = 4'($urandom_range(0, 15));
         step();
      end
      load = 1'b0;
      duty = 4'hF;

      // Reset mid-slot with a load pending
      value = 16'hBEEF;
      align(2);
      load = 1'b1;
      step();
      load = 1'b0;
      step();
      #2 rst = 1'b1;
      #1;
      chk("midrst_an", {4'h0, an}, 8'h0F);
      chk("midrst_sseg", sseg, 8'hFF);
      chk("midrst_pend", {7'h0, load_pending}, 8'h00);
      #10 rst = 1'b0;
      model_reset();
      run(40);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
